// File: rtl/display_scan_ctl_if.sv
// Scan-controller port bundle: panel-side inputs (enable, live counts, alert)
// and the digit-mux / anode outputs that the controller produces.
interface display_scan_ctl_if;
   logic       en;
   logic [3:0] occ;
   logic [3:0] liv;
   logic       alert;
   logic [1:0] ctl;
   logic [3:0] an;
   logic [3:0] occ_hold;
   logic [3:0] liv_hold;
   logic       frame_done;

   modport master (
      input  en, occ, liv, alert,
      output ctl, an, occ_hold, liv_hold, frame_done
   );

   modport slave (
      output en, occ, liv, alert,
      input  ctl, an, occ_hold, liv_hold, frame_done
   );
endinterface

// File: rtl/display_scan_ctl.sv
// 4-digit seven-segment scan controller with blanking gaps and per-frame count snapshots; DISPLAY_SCAN_BLINK_EN adds alert blinking.
// Latency: first anode lit 1 cycle after en is sampled high; all outputs registered.
// Backpressure: none; en low returns to IDLE (anodes off) on the next edge.
module display_scan_ctl #(
   parameter int DIV         = 50000,
   parameter int BLANK       = 2,
   parameter int BLINK_SHIFT = 5
) (
   input logic                clk,
   input logic                rst,
   display_scan_ctl_if.master bus
);
   localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
   // The counter only ever reaches MAXC-1, so $clog2(MAXC) bits suffice.
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    ctl_q, ctl_n;
   logic [3:0]    an_q, an_n;
   logic [3:0]    occ_q, occ_n;
   logic [3:0]    liv_q, liv_n;
   logic          fd_q, fd_n;
   logic          frame_start;
   logic          lit;

`ifdef DISPLAY_SCAN_BLINK_EN
   logic [BLINK_SHIFT:0] blink_cnt, blink_cnt_n;
   logic                 blink_off, blink_off_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else begin
         blink_cnt <= blink_cnt_n;
         blink_off <= blink_off_n;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = bus.alert & (BLINK_SHIFT >= 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ctl_q <= 2'd0;
         an_q  <= 4'b1111;
         occ_q <= 4'd0;
         liv_q <= 4'd0;
         fd_q  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ctl_q <= ctl_n;
         an_q  <= an_n;
         occ_q <= occ_n;
         liv_q <= liv_n;
         fd_q  <= fd_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      ctl_n       = ctl_q;
      frame_start = 1'b0;
      lit         = 1'b1;

      case (state)
         IDLE: begin
            if (bus.en) begin
               state_n     = ON;
               cnt_n       = '0;
               ctl_n       = 2'd0;
               frame_start = 1'b1;
            end
         end
         ON: begin
            if (cnt == DIV_LAST) begin
               cnt_n = '0;
               if (BLANK > 0) begin
                  state_n = GAP;
               end else begin
                  ctl_n       = ctl_q + 2'd1;
                  frame_start = (ctl_q == 2'd3);
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n       = '0;
               state_n     = ON;
               ctl_n       = ctl_q + 2'd1;
               frame_start = (ctl_q == 2'd3);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (!bus.en) begin
         state_n     = IDLE;
         cnt_n       = '0;
         ctl_n       = 2'd0;
         frame_start = 1'b0;
      end

`ifdef DISPLAY_SCAN_BLINK_EN
      // Phase for the new frame is bit BLINK_SHIFT of the frames-under-alert count.
      blink_cnt_n = blink_cnt;
      blink_off_n = blink_off;
      if (frame_start) begin
         if (bus.alert) begin
            blink_cnt_n = blink_cnt + 1'b1;
            blink_off_n = blink_cnt[BLINK_SHIFT];
         end else begin
            blink_cnt_n = '0;
            blink_off_n = 1'b0;
         end
      end
      lit = !blink_off_n;
`endif

      occ_n = frame_start ? bus.occ : occ_q;
      liv_n = frame_start ? bus.liv : liv_q;
      fd_n  = frame_start;
      an_n  = (state_n == ON && lit) ? ~(4'b0001 << ctl_n) : 4'b1111;
   end

   assign bus.ctl        = ctl_q;
   assign bus.an         = an_q;
   assign bus.occ_hold   = occ_q;
   assign bus.liv_hold   = liv_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctl.sv
// Bench for display_scan_ctl: two instances (with and without blanking gap)
// checked every cycle against a frame-position model plus directed spot checks.
module tb_display_scan_ctl;
   localparam int DIV_A   = 4;
   localparam int BLANK_A = 1;
   localparam int DIV_B   = 2;
   localparam int BLANK_B = 0;
   localparam int SHIFT   = 1;

   typedef struct {
      bit         act;
      int         k;
      logic [3:0] oh;
      logic [3:0] lh;
      int         n;
      bit         off;
   } model_t;

   logic   clk = 1'b0;
   logic   rst;
   model_t ma, mb;
   int     checks = 0;
   int     errors = 0;
   logic   alert_i;

   display_scan_ctl_if bus_a ();
   display_scan_ctl_if bus_b ();

   display_scan_ctl #(.DIV(DIV_A), .BLANK(BLANK_A), .BLINK_SHIFT(SHIFT)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   display_scan_ctl #(.DIV(DIV_B), .BLANK(BLANK_B), .BLINK_SHIFT(SHIFT)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: k = cycles since the scan (re)started; everything follows from k's position in the frame.
   task automatic model_step(input int div, input int blank, input logic r, input logic e,
                             input logic [3:0] o, input logic [3:0] l, input logic al,
                             inout model_t m);
      int frame;
      frame = 4 * (div + blank);
      if (r) begin
         m.act = 0; m.k = 0; m.oh = 4'd0; m.lh = 4'd0; m.n = 0; m.off = 0;
      end else if (!e) begin
         m.act = 0;
      end else begin
         if (!m.act) begin
            m.act = 1;
            m.k   = 0;
         end else begin
            m.k++;
         end
         if (m.k % frame == 0) begin
            m.oh = o;
            m.lh = l;
            m.n  = al ? m.n + 1 : 0;
`ifdef DISPLAY_SCAN_BLINK_EN
            m.off = (m.n > 0) && ((((m.n - 1) >> SHIFT) % 2) == 1);
`endif
         end
      end
   endtask

   task automatic check_dut(input string nm, input int div, input int blank, input model_t m,
                            input logic [1:0] ctl, input logic [3:0] an, input logic [3:0] oh,
                            input logic [3:0] lh, input logic fd);
      int         p, d, w;
      logic [3:0] e_an, onehot;
      logic [1:0] e_ctl;
      logic       e_fd;
      e_an = 4'b1111; e_ctl = 2'd0; e_fd = 1'b0;
      if (m.act) begin
         p      = m.k % (4 * (div + blank));
         d      = p / (div + blank);
         w      = p % (div + blank);
         e_ctl  = 2'(d);
         e_fd   = (p == 0);
         onehot = 4'b0001 << d;
         if (w < div && !m.off) e_an = ~onehot;
      end
      chk({nm, "_an"}, an, e_an);
      chk({nm, "_ctl"}, {2'b00, ctl}, {2'b00, e_ctl});
      chk({nm, "_frame_done"}, {3'b000, fd}, {3'b000, e_fd});
      chk({nm, "_occ_hold"}, oh, m.oh);
      chk({nm, "_liv_hold"}, lh, m.lh);
      chk({nm, "_one_anode"}, {3'b000, ($countones(~an) <= 1)}, 4'd1);
   endtask

   task automatic cycle(input logic r, input logic e, input logic [3:0] o, input logic [3:0] l,
                        input logic al);
      @(negedge clk);
      check_dut("a", DIV_A, BLANK_A, ma, bus_a.ctl, bus_a.an, bus_a.occ_hold, bus_a.liv_hold,
                bus_a.frame_done);
      check_dut("b", DIV_B, BLANK_B, mb, bus_b.ctl, bus_b.an, bus_b.occ_hold, bus_b.liv_hold,
                bus_b.frame_done);
      rst = r;
      bus_a.en = e; bus_a.occ = o; bus_a.liv = l; bus_a.alert = al;
      bus_b.en = e; bus_b.occ = o; bus_b.liv = l; bus_b.alert = al;
      model_step(DIV_A, BLANK_A, r, e, o, l, al, ma);
      model_step(DIV_B, BLANK_B, r, e, o, l, al, mb);
   endtask

   task automatic run(input int n, input logic r, input logic e, input logic [3:0] o,
                      input logic [3:0] l, input logic al);
      for (int i = 0; i < n; i++) cycle(r, e, o, l, al);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus_a.en = 1'b0; bus_a.occ = 4'd0; bus_a.liv = 4'd0; bus_a.alert = 1'b0;
      bus_b.en = 1'b0; bus_b.occ = 4'd0; bus_b.liv = 4'd0; bus_b.alert = 1'b0;
      model_step(DIV_A, BLANK_A, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, ma);
      model_step(DIV_B, BLANK_B, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, mb);
      repeat (2) @(posedge clk);

      // Reset then enable
      run(2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      settle();
      chk("rst_an", bus_a.an, 4'b1111);
      chk("rst_ctl", {2'b00, bus_a.ctl}, 4'd0);
      chk("rst_occ_hold", bus_a.occ_hold, 4'd0);
      run(1, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0);
      settle();
      chk("start_an", bus_a.an, 4'b1110);
      chk("start_fd", {3'b000, bus_a.frame_done}, 4'd1);
      chk("start_occ_hold", bus_a.occ_hold, 4'd3);
      chk("start_liv_hold", bus_a.liv_hold, 4'd9);
      chk("start_an_b", bus_b.an, 4'b1110);
      run(3, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0);
      settle();
      chk("digit0_last_an", bus_a.an, 4'b1110);
      run(1, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0);
      settle();
      chk("gap_an", bus_a.an, 4'b1111);
      chk("gap_ctl", {2'b00, bus_a.ctl}, 4'd0);
      run(1, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0);
      settle();
      chk("digit1_an", bus_a.an, 4'b1101);
      chk("digit1_ctl", {2'b00, bus_a.ctl}, 4'd1);
      chk("noblank_an_b", bus_b.an, 4'b1011);

      // Mid-frame Occ change stays invisible until the next frame
      run(5, 1'b0, 1'b1, 4'd5, 4'd9, 1'b0);
      settle();
      chk("digit2_ctl", {2'b00, bus_a.ctl}, 4'd2);
      chk("digit2_an", bus_a.an, 4'b1011);
      chk("midframe_occ_hold", bus_a.occ_hold, 4'd3);
      run(10, 1'b0, 1'b1, 4'd5, 4'd9, 1'b0);
      settle();
      chk("frame2_fd", {3'b000, bus_a.frame_done}, 4'd1);
      chk("frame2_an", bus_a.an, 4'b1110);
      chk("frame2_occ_hold", bus_a.occ_hold, 4'd5);

      // Disable while Ctl=10, re-enable, then reset mid-scan
      run(10, 1'b0, 1'b1, 4'd5, 4'd9, 1'b0);
      run(1, 1'b0, 1'b0, 4'd5, 4'd9, 1'b0);
      settle();
      chk("disable_an", bus_a.an, 4'b1111);
      chk("disable_ctl", {2'b00, bus_a.ctl}, 4'd0);
      chk("disable_occ_hold", bus_a.occ_hold, 4'd5);
      run(1, 1'b0, 1'b1, 4'd7, 4'd2, 1'b0);
      settle();
      chk("reen_an", bus_a.an, 4'b1110);
      chk("reen_fd", {3'b000, bus_a.frame_done}, 4'd1);
      chk("reen_occ_hold", bus_a.occ_hold, 4'd7);
      run(11, 1'b0, 1'b1, 4'd7, 4'd2, 1'b0);
      run(1, 1'b1, 1'b1, 4'd7, 4'd2, 1'b0);
      settle();
      chk("midrst_an", bus_a.an, 4'b1111);
      chk("midrst_occ_hold", bus_a.occ_hold, 4'd0);
      chk("midrst_liv_hold", bus_a.liv_hold, 4'd0);

      // Randomized traffic: long enable runs, occasional drops/resets, slow alert changes
      alert_i = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) alert_i = ~alert_i;
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
               4'($urandom), 4'($urandom), alert_i);
      end
      // Steady alert with continuous scanning to exercise full blink periods
      run(200, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1);
      run(1, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
